// File: rtl/tdnn_neuron_acc_if.sv
// tdnn_neuron_acc_if: data/weight beat stream in, rounded neuron result out
interface tdnn_neuron_acc_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data, in_weight, bias, out_data;
  logic in_valid, in_last, in_ready, out_valid, sat_flag;
  logic [1:0] act_sel_in, act_sel;
  modport master (
    output in_data, in_weight, in_valid, in_last, bias, act_sel_in,
    input  in_ready, out_data, out_valid, act_sel, sat_flag
  );
  modport slave (
    input  in_data, in_weight, in_valid, in_last, bias, act_sel_in,
    output in_ready, out_data, out_valid, act_sel, sat_flag
  );
endinterface

// File: rtl/tdnn_neuron_acc.sv
// tdnn_neuron_acc: Q8.8 dot-product MAC + bias, round half-up, saturate to Q8.8; define NEURON_ACC_STATS_EN to add sat_count
module tdnn_neuron_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_TAPS   = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic clk,
  input  logic rst_n,
  tdnn_neuron_acc_if.slave bus,
`ifdef NEURON_ACC_STATS_EN
  output logic [15:0] sat_count,
`endif
  output logic err_taps
);
  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 2;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t state, state_nxt;
  logic signed [PW-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc, prod_ext, acc_add;
  logic signed [ACC_WIDTH:0] acc_sum;
  logic signed [SW-1:0] total, rnd;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] bias_q, res;
  logic [1:0] sel_q;
  logic take, term, acc_ovf, sat_q, clip;
  assign prod = PW'($signed(bus.in_data)) * PW'($signed(bus.in_weight));
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc_sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod_ext);
  assign acc_ovf = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
  assign acc_add = acc_ovf ? (acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_WIDTH-1:0];
  assign total = SW'(acc) + (SW'($signed(bias_q)) <<< 8) + SW'(128);
  assign rnd = total >>> 8;
  assign clip = !(&rnd[SW-1:DATA_WIDTH-1] || ~|rnd[SW-1:DATA_WIDTH-1]);
  assign res = clip ? (rnd[SW-1] ? OUT_MIN : OUT_MAX) : rnd[DATA_WIDTH-1:0];
  assign take = bus.in_valid && bus.in_ready;
  assign cnt_nxt = state == IDLE ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
  assign term = bus.in_last || cnt_nxt == CNT_WIDTH'(MAX_TAPS);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: beats move IDLE->ACCUM, a last or MAX_TAPS-th beat goes to FINAL
  always_comb
    state_nxt = state == FINAL ? OUT : state == OUT ? IDLE : take ? (term ? FINAL : ACCUM) : state;
  // state-decoded handshake outputs
  always_comb begin
    bus.in_ready = state == IDLE || state == ACCUM;
    bus.out_valid = state == OUT;
  end
  // accumulate beats, finalise result in FINAL, clear in OUT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat_q <= 1'b0;
      sel_q <= '0;
      bias_q <= '0;
      err_taps <= 1'b0;
      bus.out_data <= '0;
      bus.act_sel <= '0;
      bus.sat_flag <= 1'b0;
    end else begin
      if (take) begin
        acc <= state == IDLE ? prod_ext : acc_add;
        cnt <= cnt_nxt;
        sat_q <= state != IDLE && (sat_q || acc_ovf);
        sel_q <= state == IDLE ? bus.act_sel_in : sel_q;
        bias_q <= term ? bus.bias : bias_q;
        err_taps <= err_taps || (term && !bus.in_last);
      end
      if (state == FINAL) begin
        bus.out_data <= res;
        bus.act_sel <= sel_q;
        bus.sat_flag <= sat_q || clip;
      end
      if (state == OUT) begin
        acc <= '0;
        cnt <= '0;
      end
    end
`ifdef NEURON_ACC_STATS_EN
  // count emitted saturated results, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_count <= '0;
    else if (bus.out_valid && bus.sat_flag && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
`endif
endmodule

// File: tb/tb_tdnn_neuron_acc.sv
// tb_tdnn_neuron_acc: vector table plus corner sequences, results checked through a scoreboard queue
`timescale 1ns/1ps
module tb_tdnn_neuron_acc;
  typedef struct { int n; logic [15:0] d, w, b; logic [1:0] s; logic [15:0] y; logic sat; } vec_t;
  typedef struct { logic [15:0] y; logic [1:0] s; logic sat; int cyc; } exp_t;
  logic clk = 0, rst_n = 0, err_taps;
`ifdef NEURON_ACC_STATS_EN
  logic [15:0] sat_count;
`endif
  int ncmp = 0, nfail = 0, cyc = 0, acc_cyc = 0, nsat = 0;
  exp_t q[$];
  vec_t tbl[12];
  tdnn_neuron_acc_if #(.DATA_WIDTH(16)) bus();
  tdnn_neuron_acc #(.MAX_TAPS(4), .CNT_WIDTH(7)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
`ifdef NEURON_ACC_STATS_EN
    .sat_count(sat_count),
`endif
    .err_taps(err_taps)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  // drive one beat and hold it until accepted; returns at the negedge after the accepting edge
  task automatic beat(input logic [15:0] d, w, b, input logic [1:0] s, input logic l, output int stalls);
    logic rdy;
    bit ok = 0;
    stalls = 0;
    bus.in_data = d;
    bus.in_weight = w;
    bus.bias = b;
    bus.act_sel_in = s;
    bus.in_last = l;
    bus.in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) ok = 1;
      else stalls++;
    end
    if (!ok) begin
      ncmp++;
      nfail++;
      $display("FAIL beat_timeout: got in_ready low 20 cycles want accept");
    end
    acc_cyc = cyc;
  endtask
  task automatic expect_res(input logic [15:0] y, input logic [1:0] s, input logic sat);
    exp_t e;
    e.y = y;
    e.s = s;
    e.sat = sat;
    e.cyc = acc_cyc;
    q.push_back(e);
    if (sat) nsat++;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
  endtask
  // scoreboard: every strobe must match the oldest expectation; latency counted to the capturing edge
  always @(negedge clk)
    if (bus.out_valid === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_out: got out_data %h want no result", bus.out_data);
      end else begin
        e = q.pop_front();
        chk("out_data", bus.out_data, e.y);
        chk("act_sel", bus.act_sel, e.s);
        chk("sat_flag", bus.sat_flag, e.sat);
        chk("latency", cyc + 1 - e.cyc, 2);
      end
    end
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
  initial begin
    int st;
    tbl[0]  = '{3, 16'h0100, 16'h0200, 16'h0080, 2'd1, 16'h0680, 1'b0};
    tbl[1]  = '{1, 16'h7FFF, 16'h7FFF, 16'h0000, 2'd2, 16'h7FFF, 1'b1};
    tbl[2]  = '{1, 16'h0001, 16'h0080, 16'h0000, 2'd0, 16'h0001, 1'b0};
    tbl[3]  = '{1, 16'hFFFF, 16'h0080, 16'h0000, 2'd3, 16'h0000, 1'b0};
    tbl[4]  = '{1, 16'hFF00, 16'h0100, 16'h0000, 2'd1, 16'hFF00, 1'b0};
    tbl[5]  = '{2, 16'h8000, 16'h7FFF, 16'h0000, 2'd3, 16'h8000, 1'b1};
    tbl[6]  = '{1, 16'h0100, 16'h0100, 16'hFF00, 2'd2, 16'h0000, 1'b0};
    tbl[7]  = '{2, 16'h0080, 16'h0080, 16'h0100, 2'd1, 16'h0180, 1'b0};
    tbl[8]  = '{1, 16'h0001, 16'h0001, 16'h0000, 2'd0, 16'h0000, 1'b0};
    tbl[9]  = '{1, 16'h0180, 16'h0001, 16'h0000, 2'd2, 16'h0002, 1'b0};
    tbl[10] = '{1, 16'hFE80, 16'h0001, 16'h0000, 2'd3, 16'hFFFF, 1'b0};
    tbl[11] = '{4, 16'h0100, 16'h0100, 16'h0000, 2'd0, 16'h0400, 1'b0};
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.in_data = 0;
    bus.in_weight = 0;
    bus.bias = 0;
    bus.act_sel_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_err_taps", err_taps, 0);
    rst_n = 1;
    @(negedge clk);
    foreach (tbl[r])
      for (int j = 0; j < tbl[r].n; j++) begin
        beat(tbl[r].d, tbl[r].w, tbl[r].b, tbl[r].s, j == tbl[r].n - 1, st);
        chk("stall_cycles", st, (j == 0 && r > 0) ? 2 : 0);
        if (j == tbl[r].n - 1) expect_res(tbl[r].y, tbl[r].s, tbl[r].sat);
      end
    bus.in_valid = 0;
    drain();
    chk("err_taps_clear", err_taps, 0);
    for (int i = 0; i < 4; i++) begin
      beat(16'h0100, 16'h0100, 16'h0000, i == 0 ? 2'd2 : 2'd1, 1'b0, st);
      chk("max_taps_stall", st, 0);
    end
    expect_res(16'h0400, 2'd2, 1'b0);
    beat(16'h0100, 16'h0100, 16'h0000, 2'd3, 1'b0, st);
    chk("held_beat_stall", st, 2);
    beat(16'h0100, 16'h0100, 16'h0000, 2'd0, 1'b1, st);
    chk("after_held_stall", st, 0);
    expect_res(16'h0200, 2'd3, 1'b0);
    bus.in_valid = 0;
    drain();
    chk("err_taps_set", err_taps, 1);
    repeat (3) @(negedge clk);
    chk("hold_out_valid", bus.out_valid, 0);
    chk("hold_out_data", bus.out_data, 16'h0200);
    chk("hold_act_sel", bus.act_sel, 2'd3);
`ifdef NEURON_ACC_STATS_EN
    chk("sat_count", sat_count, nsat);
`endif
    beat(16'h0100, 16'h0100, 16'h0000, 2'd1, 1'b0, st);
    beat(16'h0200, 16'h0100, 16'h0000, 2'd1, 1'b0, st);
    bus.in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_act_sel", bus.act_sel, 0);
    chk("midrst_sat_flag", bus.sat_flag, 0);
    chk("midrst_err_taps", err_taps, 0);
`ifdef NEURON_ACC_STATS_EN
    chk("midrst_sat_count", sat_count, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    beat(16'h0100, 16'h0100, 16'h0000, 2'd0, 1'b1, st);
    chk("post_rst_stall", st, 0);
    expect_res(16'h0100, 2'd0, 1'b0);
    bus.in_valid = 0;
    drain();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
